gcm_ghash_seq: RTL and testbench

Sequencer for the GHASH engine in the AES-GCM datapath. It loads the hash subkey H and streams the AAD blocks, then the ciphertext blocks, then the 128-bit length block into the GHASH core as a single message. It masks the partial final block of each segment, then XORs the GHASH result with E(K,J0) to produce the authentication tag. It sits between the AES-CTR core (ciphertext and E(K,J0) source) and the GHASH core.

---
 rtl/gcm_ghash_seq.sv | 192 +++++++++++++++++++
 tb/tb_gcm_ghash_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_ghash_seq.sv
// GHASH sequencer for AES-GCM: feeds H, AAD, text and length block
// to the GHASH core, then combines the hash with E(K,J0) into the tag.
module gcm_ghash_seq #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] aad_bits_i,
  input  logic [LEN_W-1:0] txt_bits_i,
  input  logic [127:0]     h_i,
  input  logic [127:0]     aad_i,
  input  logic             aad_valid_i,
  output logic             aad_ready_o,
  input  logic [127:0]     txt_i,
  input  logic             txt_valid_i,
  output logic             txt_ready_o,
  input  logic [127:0]     ej0_i,
  input  logic             ej0_valid_i,
  output logic [127:0]     gh_h_o,
  output logic             gh_h_valid_o,
  output logic [127:0]     gh_din_o,
  output logic             gh_din_valid_o,
  input  logic             gh_din_ready_i,
  output logic             gh_last_o,
  input  logic [127:0]     gh_dout_i,
  input  logic             gh_dout_valid_i,
  output logic [127:0]     tag_o,
  output logic             tag_valid_o,
  output logic             busy_o
);

  localparam int CW = LEN_W - 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HKEY,
    S_AAD,
    S_TXT,
    S_LEN,
    S_WAIT,
    S_TAG
  } state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0] aad_bits, txt_bits;
  logic [CW-1:0]    n_aad, n_txt;
  logic [127:0]     h_q, res_q, ej0_q, tag_q;
  logic             res_ok, ej0_ok;
  logic             aad_xfer, txt_xfer, go_tag;
  logic [127:0]     res_eff, ej0_eff;
  logic [63:0]      aad64, txt64;

  function automatic logic [CW-1:0] blocks(
    input logic [LEN_W-1:0] b
  );
    return CW'(b[LEN_W-1:7]) + CW'(|b[6:0]);
  endfunction

  // keep only the top r bits of a partial final block
  function automatic logic [127:0] keep_top(
    input logic [127:0] d,
    input logic [6:0]   r
  );
    logic [127:0] m;
    m = ~({128{1'b1}} >> r);
    return (r == 7'd0) ? d : (d & m);
  endfunction

  assign aad64   = 64'(aad_bits);
  assign txt64   = 64'(txt_bits);
  assign res_eff = res_ok ? res_q : gh_dout_i;
  assign ej0_eff = ej0_ok ? ej0_q : ej0_i;
  assign busy_o  = (state != S_IDLE);
  assign tag_o   = tag_q;

  always_comb begin
    state_nx       = state;
    aad_ready_o    = 1'b0;
    txt_ready_o    = 1'b0;
    gh_h_o         = '0;
    gh_h_valid_o   = 1'b0;
    gh_din_o       = '0;
    gh_din_valid_o = 1'b0;
    gh_last_o      = 1'b0;
    tag_valid_o    = 1'b0;
    aad_xfer       = 1'b0;
    txt_xfer       = 1'b0;
    go_tag         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_i) state_nx = S_HKEY;
      end
      S_HKEY: begin
        gh_h_valid_o = 1'b1;
        gh_h_o       = h_q;
        if (n_aad != '0)
          state_nx = S_AAD;
        else if (n_txt != '0)
          state_nx = S_TXT;
        else
          state_nx = S_LEN;
      end
      S_AAD: begin
        gh_din_valid_o = aad_valid_i;
        aad_ready_o    = gh_din_ready_i;
        aad_xfer       = aad_valid_i & gh_din_ready_i;
        gh_din_o       = (n_aad == CW'(1))
                       ? keep_top(aad_i, aad_bits[6:0])
                       : aad_i;
        if (aad_xfer && n_aad == CW'(1))
          state_nx = (n_txt != '0) ? S_TXT : S_LEN;
      end
      S_TXT: begin
        gh_din_valid_o = txt_valid_i;
        txt_ready_o    = gh_din_ready_i;
        txt_xfer       = txt_valid_i & gh_din_ready_i;
        gh_din_o       = (n_txt == CW'(1))
                       ? keep_top(txt_i, txt_bits[6:0])
                       : txt_i;
        if (txt_xfer && n_txt == CW'(1))
          state_nx = S_LEN;
      end
      S_LEN: begin
        gh_din_valid_o = 1'b1;
        gh_last_o      = 1'b1;
        gh_din_o       = {aad64, txt64};
        if (gh_din_ready_i) state_nx = S_WAIT;
      end
      S_WAIT: begin
        go_tag = (res_ok | gh_dout_valid_i)
               & (ej0_ok | ej0_valid_i);
        if (go_tag) state_nx = S_TAG;
      end
      S_TAG: begin
        tag_valid_o = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_bits <= '0;
      txt_bits <= '0;
      n_aad    <= '0;
      n_txt    <= '0;
      h_q      <= '0;
      res_q    <= '0;
      res_ok   <= 1'b0;
      ej0_q    <= '0;
      ej0_ok   <= 1'b0;
      tag_q    <= '0;
    end else begin
      if (state == S_IDLE && start_i) begin
        aad_bits <= aad_bits_i;
        txt_bits <= txt_bits_i;
        n_aad    <= blocks(aad_bits_i);
        n_txt    <= blocks(txt_bits_i);
        h_q      <= h_i;
        res_q    <= '0;
        res_ok   <= 1'b0;
        ej0_q    <= '0;
        ej0_ok   <= 1'b0;
      end
      if (aad_xfer) n_aad <= n_aad - CW'(1);
      if (txt_xfer) n_txt <= n_txt - CW'(1);
      // first E(K,J0) pulse of the message wins
      if (busy_o && state != S_TAG
          && ej0_valid_i && !ej0_ok) begin
        ej0_q  <= ej0_i;
        ej0_ok <= 1'b1;
      end
      if (state == S_WAIT
          && gh_dout_valid_i && !res_ok) begin
        res_q  <= gh_dout_i;
        res_ok <= 1'b1;
      end
      if (go_tag) tag_q <= res_eff ^ ej0_eff;
    end
  end

endmodule

// File: tb/tb_gcm_ghash_seq.sv
// Bench for gcm_ghash_seq: GHASH core mock, stream sources and a
// message-level model of the expected block stream and tag.
module tb_gcm_ghash_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [31:0]  aad_bits_i, txt_bits_i;
  logic [127:0] h_i, aad_i, txt_i, ej0_i, gh_dout_i;
  logic         aad_valid_i, txt_valid_i, ej0_valid_i;
  logic         gh_din_ready_i, gh_dout_valid_i;
  logic         aad_ready_o, txt_ready_o;
  logic [127:0] gh_h_o, gh_din_o, tag_o;
  logic         gh_h_valid_o, gh_din_valid_o, gh_last_o;
  logic         tag_valid_o, busy_o;

  int n_chk;
  int n_fail;
  logic [127:0] last_tag;

  localparam logic [127:0] H0 =
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EJ0 =
    128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C2 =
    128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T2 =
    128'hab6e47d42cec13bdf53a67b21257bddf;

  always #5 clk = ~clk;

  gcm_ghash_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .aad_bits_i      (aad_bits_i),
    .txt_bits_i      (txt_bits_i),
    .h_i             (h_i),
    .aad_i           (aad_i),
    .aad_valid_i     (aad_valid_i),
    .aad_ready_o     (aad_ready_o),
    .txt_i           (txt_i),
    .txt_valid_i     (txt_valid_i),
    .txt_ready_o     (txt_ready_o),
    .ej0_i           (ej0_i),
    .ej0_valid_i     (ej0_valid_i),
    .gh_h_o          (gh_h_o),
    .gh_h_valid_o    (gh_h_valid_o),
    .gh_din_o        (gh_din_o),
    .gh_din_valid_o  (gh_din_valid_o),
    .gh_din_ready_i  (gh_din_ready_i),
    .gh_last_o       (gh_last_o),
    .gh_dout_i       (gh_dout_i),
    .gh_dout_valid_i (gh_dout_valid_i),
    .tag_o           (tag_o),
    .tag_valid_o     (tag_valid_o),
    .busy_o          (busy_o)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  // GF(2^128) multiply, GCM bit order
  function automatic logic [127:0] gf(
    input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] keep_top(
    input logic [127:0] b, input int r);
    logic [127:0] o;
    o = b;
    if (r != 0)
      for (int k = 0; k < 128 - r; k++) o[k] = 1'b0;
    return o;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] gen(
    input int unsigned s, input int k);
    logic [127:0] r;
    int unsigned w;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      w = (s * 32'h9e3779b1)
        ^ (32'(k) * 32'h85ebca77)
        ^ (32'(i) * 32'hc2b2ae3d);
      w = w ^ (w >> 15);
      w = w * 32'h2c1b3c6d;
      w = w ^ (w >> 12);
      r[32*i +: 32] = w;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    start_i         = 1'b0;
    aad_bits_i      = '0;
    txt_bits_i      = '0;
    h_i             = '0;
    aad_i           = '0;
    aad_valid_i     = 1'b0;
    txt_i           = '0;
    txt_valid_i     = 1'b0;
    ej0_i           = '0;
    ej0_valid_i     = 1'b0;
    gh_din_ready_i  = 1'b0;
    gh_dout_i       = '0;
    gh_dout_valid_i = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_tag"}, tag_o, '0);
    chk1({p, "_tag_valid"}, tag_valid_o, 1'b0);
    chk1({p, "_busy"}, busy_o, 1'b0);
    chk1({p, "_h_valid"}, gh_h_valid_o, 1'b0);
    chk({p, "_h"}, gh_h_o, '0);
    chk1({p, "_din_valid"}, gh_din_valid_o, 1'b0);
    chk({p, "_din"}, gh_din_o, '0);
    chk1({p, "_last"}, gh_last_o, 1'b0);
    chk1({p, "_aad_ready"}, aad_ready_o, 1'b0);
    chk1({p, "_txt_ready"}, txt_ready_o, 1'b0);
  endtask

  task automatic do_abort();
    #1;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk1("abort_no_tag", tag_valid_o, 1'b0);
      chk1("abort_idle", busy_o, 1'b0);
      @(posedge clk);
    end
  endtask

  // mode: 0 ej0 at t+1, 1 five cycles after result,
  // 2 same cycle as result
  task automatic run_msg(
    input int ab, input int tbits,
    input logic [127:0] h, input logic [127:0] ej,
    input int mode, input bit bp,
    input int unsigned seed, input int abort_idx,
    input bit use_k, input logic [127:0] t0,
    input logic [127:0] tag_k);
    logic [127:0] aq[$];
    logic [127:0] tq[$];
    logic [127:0] eq[$];
    logic [127:0] blk, y, hk, ym, din, exp_tag;
    int na, nt, idx, cyc, dcyc, ecyc, tcyc;
    bit fire, lastf, afire, tfire;
    bit in_a, in_t, in_l;
    na = ab / 128 + ((ab % 128) != 0 ? 1 : 0);
    nt = tbits / 128 + ((tbits % 128) != 0 ? 1 : 0);
    for (int i = 0; i < na; i++) begin
      blk = gen(seed, i);
      aq.push_back(blk);
      eq.push_back(keep_top(blk,
        (i == na - 1) ? ab % 128 : 0));
    end
    for (int i = 0; i < nt; i++) begin
      blk = (use_k && i == 0) ? t0 : gen(seed, 1000 + i);
      tq.push_back(blk);
      eq.push_back(keep_top(blk,
        (i == nt - 1) ? tbits % 128 : 0));
    end
    eq.push_back({64'(unsigned'(ab)),
                  64'(unsigned'(tbits))});
    y = '0;
    foreach (eq[i]) y = gf(y ^ eq[i], h);
    exp_tag = y ^ ej;
    idx  = 0;
    cyc  = 0;
    dcyc = -1;
    ecyc = (mode == 0) ? 1 : -1;
    tcyc = -1;
    ym   = '0;
    hk   = '0;
    forever begin
      #1;
      start_i    = (cyc == 0) || (cyc == 2);
      aad_bits_i = (cyc == 0) ? 32'(ab) : $urandom;
      txt_bits_i = (cyc == 0) ? 32'(tbits) : $urandom;
      h_i        = (cyc == 0) ? h : rnd();
      aad_valid_i = (aq.size() != 0)
                  && (!bp || $urandom_range(0, 2) != 0);
      aad_i       = (aq.size() != 0) ? aq[0] : rnd();
      txt_valid_i = (tq.size() != 0)
                  && (!bp || $urandom_range(0, 2) != 0);
      txt_i       = (tq.size() != 0) ? tq[0] : rnd();
      gh_din_ready_i = !bp || ($urandom_range(0, 1) == 1);
      gh_dout_valid_i = (cyc == dcyc);
      gh_dout_i   = (cyc == dcyc) ? ym : rnd();
      ej0_valid_i = (cyc == ecyc)
                  || (mode == 0 && cyc == 3);
      ej0_i       = (cyc == ecyc) ? ej : rnd();
      @(negedge clk);
      in_a = cyc >= 2 && idx < na;
      in_t = cyc >= 2 && idx >= na && idx < na + nt;
      in_l = cyc >= 2 && idx == na + nt;
      chk1("h_valid", gh_h_valid_o, cyc == 1);
      if (cyc == 1) begin
        chk("h_value", gh_h_o, h);
        hk = gh_h_o;
      end
      chk1("aad_ready", aad_ready_o,
           in_a && gh_din_ready_i);
      chk1("txt_ready", txt_ready_o,
           in_t && gh_din_ready_i);
      chk1("din_valid", gh_din_valid_o,
           (in_a && aad_valid_i)
           || (in_t && txt_valid_i) || in_l);
      chk1("last", gh_last_o, in_l);
      fire  = gh_din_valid_o && gh_din_ready_i;
      lastf = gh_last_o;
      din   = gh_din_o;
      if (fire && idx < eq.size())
        chk($sformatf("blk%0d", idx), gh_din_o, eq[idx]);
      chk1("tag_valid", tag_valid_o, cyc == tcyc);
      if (cyc == tcyc) begin
        chk("tag", tag_o, exp_tag);
        if (use_k) chk("tag_known", tag_o, tag_k);
      end
      if (cyc == 0)
        chk1("busy_start", busy_o, 1'b0);
      else if (tcyc < 0 || cyc < tcyc)
        chk1("busy", busy_o, 1'b1);
      afire = aad_valid_i && aad_ready_o;
      tfire = txt_valid_i && txt_ready_o;
      @(posedge clk);
      if (cyc == tcyc) begin
        last_tag = exp_tag;
        return;
      end
      if (afire) void'(aq.pop_front());
      if (tfire) void'(tq.pop_front());
      if (fire) begin
        ym = gf(ym ^ din, hk);
        idx++;
        if (lastf) begin
          dcyc = cyc + 2;
          if (mode == 2) ecyc = dcyc;
        end
      end
      if (mode == 1 && cyc == dcyc) ecyc = cyc + 5;
      if (tcyc < 0 && dcyc >= 0 && ecyc >= 0)
        tcyc = ((dcyc > ecyc) ? dcyc : ecyc) + 1;
      if (abort_idx >= 0 && idx == abort_idx) begin
        do_abort();
        return;
      end
      cyc++;
      if (cyc > 3000) begin
        n_chk++;
        n_fail++;
        $error("FAIL timeout observed=%0d expected<%0d",
               cyc, 3000);
        return;
      end
    end
  endtask

  initial begin
    logic [127:0] hr, er;
    int ab, tbits, mode;
    n_chk    = 0;
    n_fail   = 0;
    last_tag = '0;
    rst_n    = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);

    run_msg(0, 0, H0, EJ0, 0, 0, 1, -1,
            1'b1, '0, EJ0);
    run_msg(0, 128, H0, EJ0, 0, 0, 2, -1,
            1'b1, C2, T2);

    hr = rnd();
    er = rnd();
    run_msg(160, 60, hr, er, 1, 1, 77, -1,
            1'b0, '0, '0);
    run_msg(160, 60, hr, er, 0, 1, 77, -1,
            1'b0, '0, '0);
    run_msg(160, 60, hr, er, 2, 1, 77, -1,
            1'b0, '0, '0);

    for (int i = 0; i < 4; i++) begin
      ab    = $urandom_range(0, 600);
      tbits = $urandom_range(0, 600);
      mode  = $urandom_range(0, 2);
      run_msg(ab, tbits, rnd(), rnd(), mode, 1,
              $urandom, -1, 1'b0, '0, '0);
    end

    hr = rnd();
    er = rnd();
    run_msg(256, 300, hr, er, 0, 1, 5, 3,
            1'b0, '0, '0);
    run_msg(256, 300, hr, er, 1, 1, 5, -1,
            1'b0, '0, '0);

    #1;
    idle_inputs();
    @(negedge clk);
    chk("tag_hold", tag_o, last_tag);
    chk1("end_tag_valid", tag_valid_o, 1'b0);
    chk1("end_busy", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
